cnn_win_sched: RTL and testbench
================================

Name: cnn_win_sched

Overview:
- Scheduler sitting between the bit-wide input image RAM and cnn_core.
- Walks every 3x3 window (stride 1) of an IMG_W x IMG_H binary image in raster order.
- Issues the nine RAM read addresses per window and aligns a pixel-valid strobe with the RAM's registered output.
- Only starts a window once the writer has stored its bottom-right pixel and the core is idle; raises frame_done after the last window.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)
AW, 10, RAM address width; IMG_W*IMG_H <= 2**AW required

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_clr  in  1  sync clear; restarts the frame (driven by core trmt)
wr_ptr  in  AW  count of pixels already written to RAM (monotonic within a frame)
core_bsy  in  1  core busy; no new window may start while high
addr_rd  out  AW  RAM read address (registered)
pix_vld  out  1  RAM dout this cycle is a window pixel
win_strt  out  1  first pixel of a window (coincident with its pix_vld)
win_last  out  1  ninth pixel of a window (coincident with its pix_vld)
win_row  out  5  top row of current window
win_col  out  5  left column of current window
frame_done  out  1  all windows issued; level until frame_clr

Behaviour:
- Reset values:
  - state=WAIT; r=c=0; base=0.
  - addr_rd=0; pix_vld=win_strt=win_last=frame_done=0; win_row=win_col=0.
- Window (r,c):
  - r in 0..IMG_H-3, c in 0..IMG_W-3; base = r*IMG_W + c.
  - Total windows = (IMG_W-2)*(IMG_H-2); 676 at default parameters.
- Issue order, row-major within the window:
  - base+0, +1, +2;
  - base+W, +W+1, +W+2;
  - base+2W, +2W+1, +2W+2.
  - Row offset is produced by adding IMG_W to a register; no multiplier.
- Ready condition: wr_ptr > base + 2*IMG_W + 2, evaluated at AW+1 bits, unsigned.
- States:
  - WAIT:
    - If ready && !core_bsy: go to FETCH and issue address k=0 on that clock edge.
    - Otherwise hold; addr_rd holds its last value.
  - FETCH:
    - Issues k=1..8 on consecutive cycles.
    - core_bsy and wr_ptr are ignored mid-window.
    - After k=8 is issued, advance (c,base):
      - c < IMG_W-3: c+1, base+1.
      - Else c=0, r+1, base+3.
      - Next state is WAIT, or DONE if the window just issued was (IMG_H-3, IMG_W-3).
  - DONE: no issues; holds until frame_clr.
- Output timing:
  - pix_vld, win_strt and win_last are the issue strobes delayed one cycle, matching the RAM's 1-cycle read latency.
  - win_strt goes with k=0; win_last goes with k=8.
  - win_row/win_col are registered with the k=0 issue and stay stable through that window's win_last.
  - frame_done asserts in the same cycle as the final win_last.
- Throughput: with data ready and the core idle, one window per 10 cycles (9 FETCH + 1 WAIT).
- frame_clr:
  - Highest priority.
  - Next cycle: state=WAIT; r=c=base=0; pipeline flushed (pix_vld=win_strt=win_last=0); frame_done=0.
  - Any partially issued window is abandoned.
  - Coincident with the final issue: the clear wins and frame_done never asserts.
- Reset mid-operation: identical to power-on reset, applied asynchronously.
- wr_ptr is never written by this block; stalls wait indefinitely, with no timeout.

Test Plan:
- Reset: assert rst_n=0 mid-FETCH -> all outputs 0 immediately; after release, addr_rd=0 and state=WAIT.
- First window gating: core_bsy=0; hold wr_ptr=58 for 20 cycles, then set wr_ptr=59.
  - While at 58: no pix_vld.
  - After 59: addresses 0,1,2,28,29,30,56,57,58 on consecutive cycles.
  - win_strt is on the first pix_vld, win_last on the ninth; win_row=0, win_col=0.
- Row wrap: wr_ptr=86.
  - Window (0,25) issues 25..27, 53..55, 81..83.
  - The scheduler then stalls in WAIT, because (1,0) needs wr_ptr>86.
  - wr_ptr=87 -> window (1,0) issues 28,29,30,56,57,58,84,85,86.
- Busy stall: wr_ptr=784, core_bsy=1 for 50 cycles -> no issue.
  - Drop core_bsy -> first address issued that cycle.
  - Raising core_bsy mid-window does not interrupt the window.
- Full frame: wr_ptr=784, core_bsy=0.
  - 676 win_strt pulses and 6084 pix_vld cycles.
  - Last window (25,25) ends at address 783.
  - frame_done rises with the final win_last; addr_rd stays frozen in DONE.
- Clear mid-window: pulse frame_clr at the 5th issue of window (3,7).
  - Next cycle pix_vld=0, win_row=win_col=0 path; frame_done=0.
  - With wr_ptr still 784, the next window issued is (0,0) starting at address 0.

Source files
------------

// File: rtl/cnn_win_sched.sv
// 3x3 stride-1 window scheduler between the binary image RAM and cnn_core.
// Issues nine read addresses per window and aligns strobes with the RAM's 1-cycle read latency.
//
// state    | meaning
// ---------|-----------------------------------------------------------------
// ST_WAIT  | idle between windows; start when bottom-right pixel written and core idle
// ST_FETCH | issuing k=1..8, then one cycle to advance to the next window
// ST_DONE  | every window of the frame issued; hold until frame_clr
module cnn_win_sched #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_clr_i,
    input  logic [AW-1:0] wr_ptr_i,
    input  logic          core_bsy_i,
    output logic [AW-1:0] addr_rd_o,
    output logic          pix_vld_o,
    output logic          win_strt_o,
    output logic          win_last_o,
    output logic [4:0]    win_row_o,
    output logic [4:0]    win_col_o,
    output logic          frame_done_o
);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AW:0]   READY_OFS = (AW+1)'(2 * IMG_W + 2);
    localparam logic [AW-1:0] W_STEP    = AW'(IMG_W);
    localparam logic [4:0]    LAST_R    = 5'(IMG_H - 3);
    localparam logic [4:0]    LAST_C    = 5'(IMG_W - 3);

    logic [1:0]    state_q, state_d;
    logic [4:0]    r_q, r_d;
    logic [4:0]    c_q, c_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    k_q, k_d;
    logic [1:0]    j_q, j_d;
    logic          iss_q, iss_d;
    logic          iss_strt_q, iss_strt_d;
    logic          iss_last_q, iss_last_d;
    logic          pix_vld_q, pix_vld_d;
    logic          win_strt_q, win_strt_d;
    logic          win_last_q, win_last_d;
    logic [4:0]    win_row_q, win_row_d;
    logic [4:0]    win_col_q, win_col_d;
    logic          done_q, done_d;
    logic          ready;

    // Compare one bit wider than the address so base+2W+2 cannot wrap.
    assign ready = {1'b0, wr_ptr_i} > ({1'b0, base_q} + READY_OFS);

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        base_d     = base_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        k_d        = k_q;
        j_d        = j_q;
        iss_d      = 1'b0;
        iss_strt_d = 1'b0;
        iss_last_d = 1'b0;
        pix_vld_d  = iss_q;
        win_strt_d = iss_strt_q;
        win_last_d = iss_last_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        done_d     = done_q;

        case (state_q)
            ST_WAIT: begin
                if (ready && !core_bsy_i) begin
                    state_d    = ST_FETCH;
                    addr_d     = base_q;
                    row_base_d = base_q;
                    k_d        = 4'd0;
                    j_d        = 2'd0;
                    iss_d      = 1'b1;
                    iss_strt_d = 1'b1;
                    win_row_d  = r_q;
                    win_col_d  = c_q;
                end
            end
            ST_FETCH: begin
                if (k_q != 4'd8) begin
                    iss_d      = 1'b1;
                    iss_last_d = (k_q == 4'd7);
                    k_d        = k_q + 4'd1;
                    if (j_q == 2'd2) begin
                        row_base_d = row_base_q + W_STEP;
                        addr_d     = row_base_q + W_STEP;
                        j_d        = 2'd0;
                    end else begin
                        addr_d = addr_q + AW'(1);
                        j_d    = j_q + 2'd1;
                    end
                end else if (r_q == LAST_R && c_q == LAST_C) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    if (c_q != LAST_C) begin
                        c_d    = c_q + 5'd1;
                        base_d = base_q + AW'(1);
                    end else begin
                        c_d    = 5'd0;
                        r_d    = r_q + 5'd1;
                        base_d = base_q + AW'(3);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Clear abandons any in-flight window and flushes the strobe pipeline.
        if (frame_clr_i) begin
            state_d    = ST_WAIT;
            r_d        = 5'd0;
            c_d        = 5'd0;
            base_d     = '0;
            k_d        = 4'd0;
            j_d        = 2'd0;
            iss_d      = 1'b0;
            iss_strt_d = 1'b0;
            iss_last_d = 1'b0;
            pix_vld_d  = 1'b0;
            win_strt_d = 1'b0;
            win_last_d = 1'b0;
            win_row_d  = 5'd0;
            win_col_d  = 5'd0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            r_q        <= 5'd0;
            c_q        <= 5'd0;
            base_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            k_q        <= 4'd0;
            j_q        <= 2'd0;
            iss_q      <= 1'b0;
            iss_strt_q <= 1'b0;
            iss_last_q <= 1'b0;
            pix_vld_q  <= 1'b0;
            win_strt_q <= 1'b0;
            win_last_q <= 1'b0;
            win_row_q  <= 5'd0;
            win_col_q  <= 5'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            base_q     <= base_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            k_q        <= k_d;
            j_q        <= j_d;
            iss_q      <= iss_d;
            iss_strt_q <= iss_strt_d;
            iss_last_q <= iss_last_d;
            pix_vld_q  <= pix_vld_d;
            win_strt_q <= win_strt_d;
            win_last_q <= win_last_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            done_q     <= done_d;
        end
    end

    assign addr_rd_o    = addr_q;
    assign pix_vld_o    = pix_vld_q;
    assign win_strt_o   = win_strt_q;
    assign win_last_o   = win_last_q;
    assign win_row_o    = win_row_q;
    assign win_col_o    = win_col_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_cnn_win_sched.sv
// Bench for cnn_win_sched: window-order model checked every cycle plus directed literal expectations.
module tb_cnn_win_sched;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int AW   = 10;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_clr = 1'b0;
    logic [AW-1:0] wr_ptr = '0;
    logic          core_bsy = 1'b0;
    logic [AW-1:0] addr_rd_o;
    logic          pix_vld_o, win_strt_o, win_last_o, frame_done_o;
    logic [4:0]    win_row_o, win_col_o;

    cnn_win_sched #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_clr_i (frame_clr),
        .wr_ptr_i    (wr_ptr),
        .core_bsy_i  (core_bsy),
        .addr_rd_o   (addr_rd_o),
        .pix_vld_o   (pix_vld_o),
        .win_strt_o  (win_strt_o),
        .win_last_o  (win_last_o),
        .win_row_o   (win_row_o),
        .win_col_o   (win_col_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Model: the k-th pixel of window n must be (n/(W-2))*W + n%(W-2) + (k/3)*W + k%3.
    int n_win = 0, k_pix = 0, cyc = 0;
    bit m_done = 0, clr_pend = 0;
    int a_prev = 0, w_prev1 = 0, w_prev2 = 0, b_prev1 = 0, b_prev2 = 0;
    int m_r, m_c, m_base, m_exp;
    int pix_total = 0, strt_total = 0, t_first = 0, t_last = 0;
    int seen_addr[$];
    bit seen_strt[$];
    bit seen_last[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            n_win = 0; k_pix = 0; m_done = 0;
        end else begin
            if (clr_pend) begin
                n_win = 0; k_pix = 0; m_done = 0;
            end
            if (pix_vld_o) begin
                if (m_done) begin
                    chk("pix_after_done", 1, 0);
                end else begin
                    m_r    = n_win / (W - 2);
                    m_c    = n_win % (W - 2);
                    m_base = m_r * W + m_c;
                    m_exp  = m_base + (k_pix / 3) * W + (k_pix % 3);
                    chk("pix_addr", a_prev, m_exp);
                    chk("win_strt", int'(win_strt_o), (k_pix == 0) ? 1 : 0);
                    chk("win_last", int'(win_last_o), (k_pix == 8) ? 1 : 0);
                    chk("win_row", int'(win_row_o), m_r);
                    chk("win_col", int'(win_col_o), m_c);
                    if (k_pix == 0) begin
                        chk("gate_ready", (w_prev2 > m_base + 2 * W + 2) ? 1 : 0, 1);
                        chk("gate_idle", b_prev2, 0);
                        if (n_win == 0) t_first = cyc;
                        strt_total++;
                    end
                    seen_addr.push_back(a_prev);
                    seen_strt.push_back(win_strt_o);
                    seen_last.push_back(win_last_o);
                    pix_total++;
                    k_pix++;
                    if (k_pix == 9) begin
                        k_pix = 0;
                        if (n_win == NWIN - 1) begin
                            m_done = 1;
                            t_last = cyc;
                        end else begin
                            n_win++;
                        end
                    end
                end
            end else begin
                if (k_pix != 0) chk("pix_vld_gap", 0, 1);
                chk("strobe_idle", int'({win_strt_o, win_last_o}), 0);
            end
            chk("frame_done", int'(frame_done_o), m_done ? 1 : 0);
        end
        clr_pend = frame_clr && rst_n;
        w_prev2 = w_prev1; w_prev1 = int'(wr_ptr);
        b_prev2 = b_prev1; b_prev1 = int'(core_bsy);
        a_prev  = int'(addr_rd_o);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_win(input int row, input int col, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (win_strt_o && int'(win_row_o) == row && int'(win_col_o) == col) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("timeout_wait_win", 0, 1);
    endtask

    task automatic chk_list(input string name, input int idx, input int exp[9]);
        for (int i = 0; i < 9; i++) begin
            if (idx + i < seen_addr.size()) chk(name, seen_addr[idx + i], exp[i]);
            else chk({name, "_missing"}, -1, exp[i]);
        end
    endtask

    int  snap, snap_s, idx;
    bit  ok;
    int  lst_a[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int  lst_b[9] = '{25, 26, 27, 53, 54, 55, 81, 82, 83};
    int  lst_c[9] = '{28, 29, 30, 56, 57, 58, 84, 85, 86};

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr_rd_o), 0);
        chk("rst_outs", int'({pix_vld_o, win_strt_o, win_last_o, frame_done_o}), 0);
        chk("rst_rowcol", int'({win_row_o, win_col_o}), 0);
        step(); rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_addr", int'(addr_rd_o), 0);

        // First window gated by wr_ptr
        wr_ptr = 10'd58;
        snap = pix_total;
        repeat (20) step();
        chk("gate58_no_pix", pix_total - snap, 0);
        wr_ptr = 10'd59;
        repeat (20) step();
        chk("win00_count", pix_total - snap, 9);
        chk_list("win00_addr", snap, lst_a);
        if (snap + 8 < seen_addr.size()) begin
            chk("win00_strt_first", int'(seen_strt[snap]), 1);
            chk("win00_last_ninth", int'(seen_last[snap + 8]), 1);
        end

        // Row wrap
        snap = pix_total;
        wr_ptr = 10'd86;
        repeat (300) step();
        chk("row0_count", pix_total - snap, 25 * 9);
        chk_list("win0_25_addr", snap + 24 * 9, lst_b);
        snap = pix_total;
        repeat (20) step();
        chk("stall_r1", pix_total - snap, 0);
        wr_ptr = 10'd87;
        repeat (30) step();
        chk("win10_count", pix_total - snap, 9);
        chk_list("win10_addr", snap, lst_c);

        // Busy stall
        core_bsy = 1'b1;
        wr_ptr = 10'd784;
        snap = pix_total;
        repeat (50) step();
        chk("bsy_no_pix", pix_total - snap, 0);
        core_bsy = 1'b0;
        step();
        chk("bsy_drop_addr", int'(addr_rd_o), 29);
        repeat (2) step();
        core_bsy = 1'b1;
        repeat (40) step();
        chk("bsy_mid_window", pix_total - snap, 9);

        // Asynchronous reset mid-window
        core_bsy = 1'b0;
        wait_win(1, 2, 40, ok);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_addr", int'(addr_rd_o), 0);
        chk("arst_outs", int'({pix_vld_o, win_strt_o, win_last_o, frame_done_o}), 0);
        chk("arst_rowcol", int'({win_row_o, win_col_o}), 0);
        repeat (3) step();
        snap = pix_total;
        snap_s = strt_total;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_addr", int'(addr_rd_o), 0);

        // Full frame
        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (frame_done_o) begin ok = 1; break; end
        end
        if (!ok) chk("timeout_frame", 0, 1);
        chk("frame_strt_cnt", strt_total - snap_s, 676);
        chk("frame_pix_cnt", pix_total - snap, 6084);
        chk("frame_last_addr", seen_addr[seen_addr.size() - 1], 783);
        chk("frame_throughput", t_last - t_first, 6758);
        snap = pix_total;
        repeat (20) step();
        chk("done_level", int'(frame_done_o), 1);
        chk("done_addr_frozen", int'(addr_rd_o), 783);
        chk("done_no_pix", pix_total - snap, 0);

        // Clear, then abandon window (3,7) at its 5th issue
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("clr_done_low", int'(frame_done_o), 0);
        wait_win(3, 7, 2000, ok);
        @(posedge clk);
        step();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("clr_pix_vld", int'(pix_vld_o), 0);
        chk("clr_rowcol", int'({win_row_o, win_col_o}), 0);
        chk("clr_done", int'(frame_done_o), 0);
        idx = pix_total;
        for (int i = 0; i < 30 && pix_total == idx; i++) @(negedge clk);
        if (pix_total > idx) begin
            chk("restart_addr", seen_addr[idx], 0);
            chk("restart_strt", int'(seen_strt[idx]), 1);
        end else begin
            chk("timeout_restart", 0, 1);
        end

        // Clear coincident with the final issue: frame_done must never rise
        wait_win(25, 25, 8000, ok);
        repeat (5) @(posedge clk);
        step();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("clr_final_done", int'(frame_done_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
